// File: rtl/uart_ecc_pkg.sv
// Shared types and constant helpers for the Hamming-protected UART transmitter
// and the receiver-side checker that reuses hamming_enc.
package uart_ecc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    CODE_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int code_len(int data_w);
    case (data_w)
      4:       return 7;
      11:      return 15;
      default: return 12;
    endcase
  endfunction

  function automatic int parity_cnt(int data_w);
    return (data_w == 4) ? 3 : 4;
  endfunction

  function automatic bit is_pow2(int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Payload bit index carried at codeword position p: data fills from position n downward.
  function automatic int data_index(int n, int p);
    int idx;
    idx = 0;
    for (int q = n; q > p; q--) begin
      if (!is_pow2(q)) idx++;
    end
    return idx;
  endfunction

  // Bit q-1 set for every position q whose index has bit k set.
  function automatic logic [15:0] cover_mask(int k);
    logic [15:0] m;
    m = '0;
    for (int q = 1; q <= 16; q++) begin
      if (((q >> k) & 1) == 1) m[q-1] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_enc.sv
// Combinational even-parity Hamming encoder; code bit i-1 carries position i,
// with an optional overall-parity bit appended above position N.
module hamming_enc
  import uart_ecc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SECDED = 0
) (
  input  logic [DATA_W-1:0]                   data,
  output logic [code_len(DATA_W)+SECDED-1:0]  code
);

  localparam int N = code_len(DATA_W);
  localparam int P = parity_cnt(DATA_W);

  logic [N-1:0] spread;
  logic [N-1:0] cw;
  logic [P-1:0] par;

  // Check positions are zero in spread so each mask XOR sees only payload bits.
  for (genvar p = 1; p <= N; p++) begin : g_pos
    if (is_pow2(p)) begin : g_chk_slot
      assign spread[p-1] = 1'b0;
      assign cw[p-1]     = par[$clog2(p)];
    end else begin : g_data_slot
      assign spread[p-1] = data[data_index(N, p)];
      assign cw[p-1]     = spread[p-1];
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_par
    assign par[k] = ^(spread & N'(cover_mask(k)));
  end

  if (SECDED == 1) begin : g_secded
    assign code = {^cw, cw};
  end else begin : g_sec
    assign code = cw;
  end

endmodule

// File: rtl/uart_tx_ecc.sv
// UART transmitter: start bit, Hamming codeword (LSB position first), optional
// overall parity, then 1 or 2 stop bits. tx/busy/tx_done are registered.
module uart_tx_ecc
  import uart_ecc_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 434,
  parameter int DATA_W         = 8,
  parameter int SECDED         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [1:0]        state
);

  localparam int N     = code_len(DATA_W);
  localparam int CW    = N + SECDED;
  localparam int CYC_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BIT_W = $clog2(N + 2);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] CODE_LAST = BIT_W'(CW - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  state_t            state_q, state_n;
  logic [CYC_W-1:0]  cyc_q, cyc_n;
  logic [BIT_W-1:0]  bit_q, bit_n;
  logic [CW-1:0]     shreg_q, shreg_n;
  logic [CW-1:0]     code;
  logic              tx_q, tx_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  hamming_enc #(.DATA_W(DATA_W), .SECDED(SECDED)) u_enc (
    .data (in_data),
    .code (code)
  );

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE outside reset, and in_data is sampled only then.
  assign in_ready = (state_q == IDLE) && !rst;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign state    = state_q;

  always_comb begin
    state_n = state_q;
    cyc_n   = cyc_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_n = LINE_IDLE;
        if (in_valid && in_ready) begin
          state_n = START_BIT;
          shreg_n = code;
          cyc_n   = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
        end
      end
      START_BIT: begin
        cyc_n = cyc_q + 1'b1;
        if (cyc_q == CYC_LAST) begin
          cyc_n   = '0;
          state_n = CODE_BITS;
          tx_n    = shreg_q[0];
          shreg_n = shreg_q >> 1;
        end
      end
      CODE_BITS: begin
        cyc_n = cyc_q + 1'b1;
        if (cyc_q == CYC_LAST) begin
          cyc_n = '0;
          if (bit_q == CODE_LAST) begin
            state_n = STOP_BIT;
            bit_n   = '0;
            tx_n    = LINE_IDLE;
          end else begin
            bit_n   = bit_q + 1'b1;
            tx_n    = shreg_q[0];
            shreg_n = shreg_q >> 1;
          end
        end
      end
      STOP_BIT: begin
        cyc_n = cyc_q + 1'b1;
        if (cyc_q == CYC_LAST) begin
          cyc_n = '0;
          if (bit_q == STOP_LAST) begin
            state_n = IDLE;
            bit_n   = '0;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = LINE_IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cyc_q   <= cyc_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_ecc.sv
// Bench for uart_tx_ecc: several parameterisations side by side, every line cycle
// compared against a syndrome-based Hamming reference and a codeword scoreboard.
module tb_uart_tx_ecc;

  localparam int NI = 5;
  localparam int DW_T  [NI] = '{8, 8, 4, 8, 11};
  localparam int SEC_T [NI] = '{0, 1, 0, 0, 1};
  localparam int SB_T  [NI] = '{1, 1, 2, 1, 2};
  localparam int CPB_T [NI] = '{4, 4, 4, 434, 3};

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        in_valid [NI];
  logic [15:0] in_data  [NI];
  logic        in_ready [NI];
  logic        tx       [NI];
  logic        busy     [NI];
  logic        tx_done  [NI];
  logic [1:0]  state    [NI];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_cw;

  // ---------------- clock / reset ----------------
  always #10 clk_50M = ~clk_50M;

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_ecc #(
      .CYCLES_PER_BIT (CPB_T[g]),
      .DATA_W         (DW_T[g]),
      .SECDED         (SEC_T[g]),
      .STOP_BITS      (SB_T[g])
    ) u_dut (
      .clk_50M  (clk_50M),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g][DW_T[g]-1:0]),
      .in_ready (in_ready[g]),
      .tx       (tx[g]),
      .busy     (busy[g]),
      .tx_done  (tx_done[g]),
      .state    (state[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference Hamming model ----------------
  function automatic int n_of(int dw);
    int p;
    p = 0;
    while ((1 << p) < dw + p + 1) p++;
    return dw + p;
  endfunction

  function automatic int data_pos(int dw, int j);
    int seen;
    seen = 0;
    for (int pos = n_of(dw); pos > 0; pos--) begin
      if ((pos & (pos - 1)) != 0) begin
        if (seen == j) return pos;
        seen++;
      end
    end
    return 0;
  endfunction

  // Check bits are chosen so the XOR of the indices of all set positions is zero.
  function automatic logic [15:0] ref_encode(int g, logic [15:0] word);
    logic [15:0] cw;
    int n, syn, pos;
    n = n_of(DW_T[g]);
    cw = '0;
    syn = 0;
    for (int j = 0; j < DW_T[g]; j++) begin
      if (word[j]) begin
        pos = data_pos(DW_T[g], j);
        cw[pos-1] = 1'b1;
        syn ^= pos;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if ((1 << k) <= n && syn[k]) cw[(1 << k) - 1] = 1'b1;
    end
    if (SEC_T[g] == 1) cw[n] = ^cw;
    return cw;
  endfunction

  function automatic int syndrome(int g, logic [15:0] cw);
    int s, par, n;
    n = n_of(DW_T[g]);
    s = 0;
    par = 0;
    for (int p = 1; p <= n + SEC_T[g]; p++) begin
      if (cw[p-1]) begin
        if (p <= n) s ^= p;
        par ^= 1;
      end
    end
    return (SEC_T[g] == 1) ? (s | (par << 4)) : s;
  endfunction

  function automatic logic [15:0] ref_decode(int g, logic [15:0] cw);
    logic [15:0] d;
    d = '0;
    for (int j = 0; j < DW_T[g]; j++) d[j] = cw[data_pos(DW_T[g], j) - 1];
    return d;
  endfunction

  // ---------------- driver + line monitor ----------------
  task automatic run_frame(input int g, input logic [15:0] word, input bit hold_next,
                           input logic [15:0] next_word, output int waited);
    int          nb, f, cpb, ok, done_cnt, busy_cnt;
    logic [15:0] cw_exp, rx_bits, exp_cw, mask;
    logic        lvl;
    cpb = CPB_T[g];
    nb  = n_of(DW_T[g]) + SEC_T[g];
    f   = 1 + nb + SB_T[g];
    mask = 16'((32'd1 << DW_T[g]) - 1);
    in_valid[g] = 1'b1;
    in_data[g]  = word;
    waited = 0;
    while (in_ready[g] !== 1'b1 && waited < 10000) begin
      @(negedge clk_50M);
      waited++;
    end
    if (in_ready[g] !== 1'b1) begin
      check($sformatf("g%0d_accept_timeout", g), 0, 1);
      in_valid[g] = 1'b0;
      return;
    end
    @(posedge clk_50M);
    cw_exp = ref_encode(g, word);
    exp_q.push_back(cw_exp);
    rx_bits = '0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int b = 0; b < f; b++) begin
      lvl = (b == 0) ? 1'b0 : (b <= nb) ? cw_exp[b-1] : 1'b1;
      ok = 0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk_50M);
        if (tx[g] === lvl) ok++;
        if (tx_done[g] === 1'b1) done_cnt++;
        if (busy[g] === 1'b1) busy_cnt++;
        if (c == cpb / 2 && b >= 1 && b <= nb) rx_bits[b-1] = tx[g];
        if (hold_next) begin
          in_data[g] = (b == f - 1 && c == cpb - 1) ? next_word : 16'($urandom);
        end else begin
          in_valid[g] = 1'b0;
          in_data[g]  = 16'($urandom);
        end
      end
      check($sformatf("g%0d_bit%0d_cycles", g, b), ok, cpb);
    end
    @(negedge clk_50M);
    check($sformatf("g%0d_frame_end", g), {tx_done[g], busy[g], in_ready[g], tx[g]}, 4'b1011);
    check($sformatf("g%0d_done_during_frame", g), done_cnt, 0);
    check($sformatf("g%0d_busy_cycles", g), busy_cnt, f * cpb);
    exp_cw = exp_q.pop_front();
    check($sformatf("g%0d_codeword", g), rx_bits, exp_cw);
    check($sformatf("g%0d_decoded", g), ref_decode(g, rx_bits), word & mask);
    check($sformatf("g%0d_syndrome", g), syndrome(g, rx_bits), 0);
    last_cw = rx_bits;
    if (!hold_next) begin
      @(negedge clk_50M);
      check($sformatf("g%0d_done_one_cycle", g), tx_done[g], 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, w1, bad;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0;
      in_data[g]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk_50M);
    for (int g = 0; g < NI; g++)
      check($sformatf("g%0d_reset_state", g),
            {tx[g], busy[g], tx_done[g], in_ready[g], state[g]}, 6'b100000);
    rst = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      check($sformatf("g%0d_ready_after_reset", g), in_ready[g], 1'b1);
    @(negedge clk_50M);

    run_frame(0, 16'h00A5, 1'b0, 16'h0, w0);
    check("a5_codeword", last_cw, 16'h0A27);
    run_frame(1, 16'h00FF, 1'b0, 16'h0, w0);
    check("ff_secded_codeword", last_cw, 16'h0F77);
    run_frame(1, 16'h0000, 1'b0, 16'h0, w0);
    check("zero_secded_codeword", last_cw, 16'h0000);
    run_frame(2, 16'h000B, 1'b0, 16'h0, w0);
    check("dw4_stop2_codeword", last_cw, 16'h0066);

    run_frame(0, 16'h003C, 1'b1, 16'h00C3, w0);
    run_frame(0, 16'h00C3, 1'b0, 16'h0, w1);
    check("b2b_gap_cycles", w1, 0);

    for (int g = 0; g < NI; g++) begin
      if (CPB_T[g] < 100) begin
        repeat (4) run_frame(g, 16'($urandom), 1'b0, 16'h0, w0);
      end
    end

    run_frame(3, 16'h005A, 1'b0, 16'h0, w0);
    run_frame(3, 16'($urandom), 1'b0, 16'h0, w0);

    // Abort a frame with a 3-cycle reset in the middle of the code bits.
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h00F0;
    @(posedge clk_50M);
    @(negedge clk_50M);
    in_valid[0] = 1'b0;
    repeat (9) @(negedge clk_50M);
    check("busy_before_reset", busy[0], 1'b1);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk_50M);
      check("mid_frame_reset", {tx[0], busy[0], tx_done[0], in_ready[0], state[0]}, 6'b100000);
    end
    rst = 1'b0;
    #1;
    check("ready_after_mid_reset", in_ready[0], 1'b1);
    bad = 0;
    repeat (80) begin
      @(negedge clk_50M);
      if (tx[0] !== 1'b1 || tx_done[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    check("line_idle_after_abort", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
